// File: rtl/pio_mbox_pkg.sv
// Shared types and constants for the PIO toggle-handshake mailbox responder.
package pio_mbox_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        CMD,
        RSP
    } state_e;

    localparam int unsigned TOGGLE_BIT = 31;
    localparam int unsigned PAYLOAD_W  = 31;

    localparam logic [PAYLOAD_W-1:0] DEFAULT_TIMEOUT_CODE = 31'h7FFF_FFFF;

endpackage

// File: rtl/pio_bus_sync.sv
// WIDTH-bit x STAGES-deep flop chain bringing a host-written bus into the block clock domain.
module pio_bus_sync #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift the input word down the chain; reset clears every stage to zero.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pio_mailbox_responder.sv
// Fabric-side responder for a toggle-handshake mailbox over two 32-bit PIO exports.
// Captures a host command, hands it to user logic over valid/ready, returns the
// user response (or a watchdog error code) with the ack toggle matching the request.
module pio_mailbox_responder
    import pio_mbox_pkg::*;
#(
    parameter int unsigned          SYNC_STAGES    = 2,
    parameter int unsigned          TIMEOUT_CYCLES = 1000000,
    parameter logic [PAYLOAD_W-1:0] TIMEOUT_CODE   = DEFAULT_TIMEOUT_CODE
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [31:0]          mbox_out_export,
    output logic [31:0]          mbox_in_export,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [PAYLOAD_W-1:0] cmd_data,
    input  logic                 rsp_valid,
    output logic                 rsp_ready,
    input  logic [PAYLOAD_W-1:0] rsp_data,
    output logic                 busy,
    output logic [7:0]           timeout_count
);

    // Timer value on the last permitted cycle; unused when the watchdog is disabled.
    localparam logic [31:0] TMAX = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    logic [31:0]          sw;
    state_e               state_q, state_d;
    logic [PAYLOAD_W-1:0] cmd_data_q, cmd_data_d;
    logic                 req_tog_q, req_tog_d;
    logic [31:0]          mbox_in_q, mbox_in_d;
    logic [31:0]          timer_q, timer_d;
    logic [7:0]           tcnt_q, tcnt_d;
    logic                 timeout_hit;

    pio_bus_sync #(
        .WIDTH  (32),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_clk),
        .rst_ni (reset_reset_n),
        .d_i    (mbox_out_export),
        .q_o    (sw)
    );

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TMAX);

    // Next-state logic: request detect, capture, command/response handshakes and watchdog.
    always_comb begin
        state_d    = state_q;
        cmd_data_d = cmd_data_q;
        req_tog_d  = req_tog_q;
        mbox_in_d  = mbox_in_q;
        timer_d    = timer_q;
        tcnt_d     = tcnt_q;
        case (state_q)
            IDLE: begin
                if (sw[TOGGLE_BIT] != mbox_in_q[TOGGLE_BIT]) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                cmd_data_d = sw[PAYLOAD_W-1:0];
                req_tog_d  = sw[TOGGLE_BIT];
                timer_d    = '0;
                state_d    = CMD;
            end
            CMD: begin
                timer_d = timer_q + 32'd1;
                if (cmd_ready) begin
                    state_d = RSP;
                end else if (timeout_hit) begin
                    mbox_in_d = {req_tog_q, TIMEOUT_CODE};
                    tcnt_d    = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
                    state_d   = IDLE;
                end
            end
            RSP: begin
                timer_d = timer_q + 32'd1;
                if (rsp_valid) begin
                    mbox_in_d = {req_tog_q, rsp_data};
                    state_d   = IDLE;
                end else if (timeout_hit) begin
                    mbox_in_d = {req_tog_q, TIMEOUT_CODE};
                    tcnt_d    = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q    <= IDLE;
            cmd_data_q <= '0;
            req_tog_q  <= 1'b0;
            mbox_in_q  <= '0;
            timer_q    <= '0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            cmd_data_q <= cmd_data_d;
            req_tog_q  <= req_tog_d;
            mbox_in_q  <= mbox_in_d;
            timer_q    <= timer_d;
            tcnt_q     <= tcnt_d;
        end
    end

    assign mbox_in_export = mbox_in_q;
    assign cmd_valid      = (state_q == CMD);
    assign cmd_data       = cmd_data_q;
    assign rsp_ready      = (state_q == RSP);
    assign busy           = (state_q != IDLE);
    assign timeout_count  = tcnt_q;

endmodule

// File: tb/tb_pio_mailbox_responder.sv
// Scoreboard bench for pio_mailbox_responder: directed host/user stimulus pushes
// expected commands and ack words; a negedge monitor pops and compares them.
module tb_pio_mailbox_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] mbox_out;
    logic [31:0] mbox_in;
    logic        cmd_valid, cmd_ready;
    logic [30:0] cmd_data;
    logic        rsp_valid, rsp_ready;
    logic [30:0] rsp_data;
    logic        busy;
    logic [7:0]  timeout_count;

    int checks = 0;
    int errors = 0;

    logic [30:0] exp_cmd_q [$];
    logic [31:0] exp_ack_q [$];
    logic [31:0] prev_in = '0;

    always #5 clk = ~clk;

    pio_mailbox_responder #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (16),
        .TIMEOUT_CODE   (31'h7FFF_FFFF)
    ) dut (
        .clk_clk         (clk),
        .reset_reset_n   (reset_n),
        .mbox_out_export (mbox_out),
        .mbox_in_export  (mbox_in),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_data        (cmd_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .busy            (busy),
        .timeout_count   (timeout_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every command handshake and every ack write.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_in = mbox_in;
        end else begin
            if (cmd_valid && cmd_ready) begin
                if (exp_cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: got cmd_data %h, none expected", cmd_data);
                end else begin
                    chk("cmd_data", {1'b0, cmd_data}, {1'b0, exp_cmd_q.pop_front()});
                end
            end
            if (mbox_in !== prev_in) begin
                if (exp_ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got %h, none expected", mbox_in);
                end else begin
                    chk("ack_word", mbox_in, exp_ack_q.pop_front());
                end
            end
            prev_in = mbox_in;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd_valid(output int n);
        n = 0;
        while (!cmd_valid) begin
            tick();
            n++;
            if (n > 60) begin
                checks++;
                errors++;
                $display("FAIL cmd_valid_timeout: got no cmd_valid, expected one within 60 cycles");
                n = -1;
                return;
            end
        end
    endtask

    task automatic wait_ack(output int n);
        logic [31:0] old;
        old = mbox_in;
        n = 0;
        while (mbox_in === old) begin
            tick();
            n++;
            if (n > 60) begin
                checks++;
                errors++;
                $display("FAIL ack_timeout: got no ack change, expected one within 60 cycles");
                n = -1;
                return;
            end
        end
    endtask

    task automatic expect_idle(input string name, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (busy || cmd_valid) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_mbox_in"}, mbox_in, 32'h0);
        chk({tag, "_cmd_valid"}, {31'b0, cmd_valid}, 32'h0);
        chk({tag, "_cmd_data"}, {1'b0, cmd_data}, 32'h0);
        chk({tag, "_rsp_ready"}, {31'b0, rsp_ready}, 32'h0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
        chk({tag, "_timeout_count"}, {24'b0, timeout_count}, 32'h0);
    endtask

    initial begin
        int n;
        reset_n   = 1'b0;
        mbox_out  = '0;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        repeat (3) tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        repeat (3) tick();

        // Basic round trip with ready/valid tied high.
        cmd_ready = 1'b1;
        rsp_valid = 1'b1;
        rsp_data  = 31'h0000_0456;
        exp_cmd_q.push_back(31'h123);
        exp_ack_q.push_back(32'h8000_0456);
        mbox_out = 32'h8000_0123;
        wait_cmd_valid(n);
        chk("cmd_valid_latency", 32'(n), 32'd4);
        wait_ack(n);
        chk("ack_after_cmd_valid", 32'(n), 32'd2);
        chk("busy_after_ack", {31'b0, busy}, 32'h0);
        repeat (3) tick();

        // Toggle back, then the held word must not start another request.
        rsp_data = 31'h55;
        exp_cmd_q.push_back(31'hAA);
        exp_ack_q.push_back(32'h0000_0055);
        mbox_out = 32'h0000_00AA;
        wait_cmd_valid(n);
        wait_ack(n);
        chk("toggle_back_ack", mbox_in, 32'h0000_0055);
        expect_idle("no_repeat_request", 20);

        // Backpressure: 10 cycles of cmd_ready low; the response lands on the timeout cycle.
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = 31'h0CCC;
        exp_cmd_q.push_back(31'h0BBB);
        exp_ack_q.push_back(32'h8000_0CCC);
        mbox_out = 32'h8000_0BBB;
        wait_cmd_valid(n);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (!cmd_valid || cmd_data !== 31'h0BBB) n++;
            tick();
        end
        chk("cmd_stable_under_backpressure", 32'(n), 32'd0);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("rsp_ready_after_cmd_hs", {31'b0, rsp_ready}, 32'h1);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mbox_in !== 32'h0000_0055 || !rsp_ready) n++;
        end
        chk("no_ack_before_rsp_hs", 32'(n), 32'd0);
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        chk("collision_user_data_wins", mbox_in, 32'h8000_0CCC);
        chk("collision_timeout_count", {24'b0, timeout_count}, 32'd0);
        repeat (3) tick();

        // Watchdog in RSP: command accepted, user never responds.
        cmd_ready = 1'b1;
        exp_cmd_q.push_back(31'h111);
        exp_ack_q.push_back(32'h7FFF_FFFF);
        mbox_out = 32'h0000_0111;
        wait_cmd_valid(n);
        wait_ack(n);
        chk("rsp_timeout_cycles", 32'(n), 32'd16);
        chk("rsp_timeout_code", mbox_in, 32'h7FFF_FFFF);
        chk("rsp_timeout_count", {24'b0, timeout_count}, 32'd1);
        repeat (3) tick();

        // Watchdog in CMD: command never accepted and is dropped.
        cmd_ready = 1'b0;
        exp_ack_q.push_back(32'hFFFF_FFFF);
        mbox_out = 32'h8000_0222;
        wait_cmd_valid(n);
        wait_ack(n);
        chk("cmd_timeout_cycles", 32'(n), 32'd16);
        chk("cmd_timeout_drops_valid", {31'b0, cmd_valid}, 32'h0);
        chk("cmd_timeout_count", {24'b0, timeout_count}, 32'd2);
        repeat (3) tick();

        // Host glitch: payload rewritten during RSP is ignored.
        cmd_ready = 1'b1;
        rsp_data  = 31'h334;
        exp_cmd_q.push_back(31'h333);
        exp_ack_q.push_back(32'h0000_0334);
        mbox_out = 32'h0000_0333;
        wait_cmd_valid(n);
        tick();
        chk("glitch_in_rsp", {31'b0, rsp_ready}, 32'h1);
        mbox_out = 32'h0000_0999;
        repeat (5) tick();
        rsp_valid = 1'b1;
        wait_ack(n);
        rsp_valid = 1'b0;
        chk("glitch_ack", mbox_in, 32'h0000_0334);
        expect_idle("glitch_no_second_request", 20);

        // Mid-operation reset during RSP with host toggle held at 1.
        exp_cmd_q.push_back(31'h444);
        mbox_out = 32'h8000_0444;
        wait_cmd_valid(n);
        tick();
        chk("pre_reset_in_rsp", {31'b0, rsp_ready}, 32'h1);
        reset_n = 1'b0;
        tick();
        tick();
        check_reset_values("midreset");
        exp_cmd_q.push_back(31'h444);
        exp_ack_q.push_back(32'h8000_0445);
        rsp_data  = 31'h445;
        rsp_valid = 1'b1;
        reset_n   = 1'b1;
        wait_cmd_valid(n);
        chk("post_reset_cmd_latency", 32'(n), 32'd4);
        chk("post_reset_cmd_data", {1'b0, cmd_data}, 32'h0000_0444);
        wait_ack(n);
        rsp_valid = 1'b0;
        repeat (3) tick();

        chk("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'd0);
        chk("ack_queue_drained", 32'(exp_ack_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
